order_manager: RTL and testbench

Downstream stage of the momentum strategy. Consumes the per-cycle `buy_signal`/`sell_signal` decisions and turns them into an order stream. Along the way it aligns the decisions with the stock ID and price that produced them, enforces a per-stock position limit and cooldown, and buffers orders in a small FIFO. The FIFO feeds the exchange/order-entry interface over a valid/ready handshake.

---
 rtl/silicon_pkg.sv | 20 ++
 rtl/order_fifo.sv | 69 ++++++
 rtl/order_manager.sv | 127 ++++++++++++
 tb/tb_order_manager.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/silicon_pkg.sv
// Shared types and constants for the strategy-to-order datapath.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package silicon_pkg;

    localparam int STOCK_ID_W = 2;
    localparam int PRICE_W    = 14;
    localparam int NUM_STOCKS = 4;

    localparam logic SIDE_BUY  = 1'b1;
    localparam logic SIDE_SELL = 1'b0;

    // One queued order as presented to the order-entry interface
    typedef struct packed {
        logic                  side;
        logic [STOCK_ID_W-1:0] stock_id;
        logic [PRICE_W-1:0]    price;
    } order_t;

endpackage

// File: rtl/order_fifo.sv
// Show-ahead order FIFO; head is always driven straight from storage.
// Latency: a push becomes visible at the head one edge later (no empty bypass).
// Backpressure: push is ignored when full unless a pop happens on the same edge.
module order_fifo
    import silicon_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push_i,
    input  order_t din_i,
    input  logic   pop_i,
    output order_t dout_o,
    output logic   full_o,
    output logic   empty_o
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry an extra wrap bit so full and empty are distinguishable
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    order_t      mem_q [DEPTH];

    logic do_push;
    logic do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A full FIFO still accepts a push when the head leaves on the same edge;
    // the freed slot is exactly the one the write pointer lands on.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    assign dout_o = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // Pointer and storage registers; reset clears storage so the head reads zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (do_push) begin
                mem_q[wr_ptr_q[AW-1:0]] <= din_i;
            end
        end
    end

endmodule

// File: rtl/order_manager.sv
// Turns registered buy/sell decisions into orders with position limit and cooldown.
// Latency: 2 edges from enable sample to order_valid (align, then commit into FIFO).
// Backpressure: order_ready stalls the FIFO head; requests arriving while full are dropped and counted.
module order_manager
    import silicon_pkg::*;
#(
    parameter int MAX_POS    = 4,
    parameter int COOLDOWN   = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [STOCK_ID_W-1:0] stock_id,
    input  logic [PRICE_W-1:0]    current_price,
    input  logic                  buy_signal,
    input  logic                  sell_signal,
    output logic                  order_valid,
    input  logic                  order_ready,
    output logic                  order_side,
    output logic [STOCK_ID_W-1:0] order_stock_id,
    output logic [PRICE_W-1:0]    order_price,
    input  logic [STOCK_ID_W-1:0] pos_rd_id,
    output logic [3:0]            pos_rd_data,
    output logic [7:0]            drop_count
);

    localparam logic [3:0] MAX_POS_L  = 4'(MAX_POS);
    localparam logic [7:0] COOLDOWN_L = 8'(COOLDOWN);

    // Inputs delayed by one edge so they line up with the registered strategy outputs
    logic                  en_q;
    logic [STOCK_ID_W-1:0] id_q;
    logic [PRICE_W-1:0]    px_q;

    logic [3:0] pos_q  [NUM_STOCKS];
    logic [3:0] pos_d  [NUM_STOCKS];
    logic [7:0] cool_q [NUM_STOCKS];
    logic [7:0] cool_d [NUM_STOCKS];
    logic [7:0] drop_q, drop_d;

    logic   buy_req;
    logic   sell_req;
    logic   req;
    logic   pop;
    logic   can_push;
    logic   commit;
    order_t push_dat;
    order_t head_dat;
    logic   fifo_full;
    logic   fifo_empty;

    // Request qualification uses the pre-edge position and cooldown of the aligned stock
    always_comb begin
        buy_req  = en_q & buy_signal & ~sell_signal &
                   (pos_q[id_q] < MAX_POS_L) & (cool_q[id_q] == 8'd0);
        sell_req = en_q & sell_signal & ~buy_signal &
                   (pos_q[id_q] != 4'd0) & (cool_q[id_q] == 8'd0);
        req      = buy_req | sell_req;
        pop      = order_valid & order_ready;
        can_push = ~fifo_full | pop;
        commit   = req & can_push;
        push_dat.side     = buy_req ? SIDE_BUY : SIDE_SELL;
        push_dat.stock_id = id_q;
        push_dat.price    = px_q;
    end

    // Position, cooldown and drop-counter next-state
    always_comb begin
        for (int i = 0; i < NUM_STOCKS; i++) begin
            pos_d[i]  = pos_q[i];
            cool_d[i] = (cool_q[i] != 8'd0) ? cool_q[i] - 8'd1 : 8'd0;
        end
        drop_d = drop_q;
        if (commit) begin
            pos_d[id_q]  = buy_req ? pos_q[id_q] + 4'd1 : pos_q[id_q] - 4'd1;
            cool_d[id_q] = COOLDOWN_L;
        end
        if (req && !can_push && drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
        end
    end

    // Alignment and per-stock state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q   <= 1'b0;
            id_q   <= '0;
            px_q   <= '0;
            drop_q <= '0;
            for (int i = 0; i < NUM_STOCKS; i++) begin
                pos_q[i]  <= '0;
                cool_q[i] <= '0;
            end
        end else begin
            en_q   <= enable;
            id_q   <= stock_id;
            px_q   <= current_price;
            drop_q <= drop_d;
            for (int i = 0; i < NUM_STOCKS; i++) begin
                pos_q[i]  <= pos_d[i];
                cool_q[i] <= cool_d[i];
            end
        end
    end

    order_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (commit),
        .din_i   (push_dat),
        .pop_i   (pop),
        .dout_o  (head_dat),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign order_valid    = ~fifo_empty;
    assign order_side     = head_dat.side;
    assign order_stock_id = head_dat.stock_id;
    assign order_price    = head_dat.price;
    assign pos_rd_data    = pos_q[pos_rd_id];
    assign drop_count     = drop_q;

endmodule

// File: tb/tb_order_manager.sv
module tb_order_manager;
    import silicon_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [1:0]  stock_id = '0;
    logic [13:0] current_price = '0;
    logic        buy_signal = 1'b0;
    logic        sell_signal = 1'b0;
    logic        order_ready = 1'b0;
    logic [1:0]  pos_rd_id = '0;

    // Instance A: MAX_POS=2, no cooldown
    logic        a_valid, a_side;
    logic [1:0]  a_id;
    logic [13:0] a_price;
    logic [3:0]  a_pos;
    logic [7:0]  a_drop;
    // Instance B: MAX_POS=4, COOLDOWN=3
    logic        b_valid, b_side;
    logic [1:0]  b_id;
    logic [13:0] b_price;
    logic [3:0]  b_pos;
    logic [7:0]  b_drop;

    int pass_cnt = 0;
    int fail_cnt = 0;

    always #5 clk = ~clk;

    order_manager #(.MAX_POS(2), .COOLDOWN(0), .FIFO_DEPTH(4)) dut_a (
        .clk(clk), .rst(rst), .enable(enable), .stock_id(stock_id),
        .current_price(current_price), .buy_signal(buy_signal), .sell_signal(sell_signal),
        .order_valid(a_valid), .order_ready(order_ready), .order_side(a_side),
        .order_stock_id(a_id), .order_price(a_price), .pos_rd_id(pos_rd_id),
        .pos_rd_data(a_pos), .drop_count(a_drop)
    );

    order_manager #(.MAX_POS(4), .COOLDOWN(3), .FIFO_DEPTH(4)) dut_b (
        .clk(clk), .rst(rst), .enable(enable), .stock_id(stock_id),
        .current_price(current_price), .buy_signal(buy_signal), .sell_signal(sell_signal),
        .order_valid(b_valid), .order_ready(order_ready), .order_side(b_side),
        .order_stock_id(b_id), .order_price(b_price), .pos_rd_id(pos_rd_id),
        .pos_rd_data(b_pos), .drop_count(b_drop)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // One isolated decision: present id/price, then the strategy answer one cycle later
    task automatic decide(input logic [1:0] id, input logic [13:0] px,
                          input logic b, input logic s);
        enable = 1'b1; stock_id = id; current_price = px;
        buy_signal = 1'b0; sell_signal = 1'b0;
        tick();
        enable = 1'b0; buy_signal = b; sell_signal = s;
        tick();
        buy_signal = 1'b0; sell_signal = 1'b0;
    endtask

    task automatic rd_pos_a(input string tag, input logic [1:0] id, input logic [3:0] exp);
        pos_rd_id = id;
        #1;
        chk(tag, 32'(a_pos), 32'(exp));
    endtask

    initial begin
        int cnt;
        logic [11:0] pattern;

        // Reset state
        tick();
        tick();
        chk("rst_valid", 32'(a_valid), 0);
        chk("rst_side", 32'(a_side), 0);
        chk("rst_id", 32'(a_id), 0);
        chk("rst_price", 32'(a_price), 0);
        chk("rst_drop", 32'(a_drop), 0);
        rd_pos_a("rst_pos1", 2'd1, 4'd0);
        rst = 1'b0;

        // Basic buy: 2-edge latency
        decide(2'd1, 14'd800, 1'b1, 1'b0);
        chk("buy_valid", 32'(a_valid), 1);
        chk("buy_side", 32'(a_side), 1);
        chk("buy_id", 32'(a_id), 1);
        chk("buy_price", 32'(a_price), 800);
        rd_pos_a("buy_pos", 2'd1, 4'd1);
        order_ready = 1'b1;
        tick();
        chk("buy_drained", 32'(a_valid), 0);

        // Position limit on instance A (MAX_POS=2)
        order_ready = 1'b0;
        do_reset();
        order_ready = 1'b1;
        enable = 1'b1; stock_id = 2'd2; current_price = 14'd100; buy_signal = 1'b1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (a_valid) cnt++;
            if (i == 5) begin
                enable = 1'b0; buy_signal = 1'b0;
            end
        end
        chk("lim_orders", 32'(cnt), 2);
        rd_pos_a("lim_pos", 2'd2, 4'd2);
        decide(2'd2, 14'd150, 1'b0, 1'b1);
        chk("lim_sell_valid", 32'(a_valid), 1);
        chk("lim_sell_side", 32'(a_side), 0);
        chk("lim_sell_price", 32'(a_price), 150);
        rd_pos_a("lim_sell_pos", 2'd2, 4'd1);
        tick();
        chk("lim_sell_drained", 32'(a_valid), 0);

        // Cooldown on instance B (COOLDOWN=3): commits every 4th decision
        order_ready = 1'b0;
        do_reset();
        order_ready = 1'b1;
        enable = 1'b1; stock_id = 2'd0; current_price = 14'd500; buy_signal = 1'b1;
        tick();
        pattern = '0;
        for (int i = 0; i < 12; i++) begin
            tick();
            pattern[11-i] = b_valid;
        end
        enable = 1'b0; buy_signal = 1'b0;
        chk("cool_pattern", 32'(pattern), 32'h888);
        pos_rd_id = 2'd0;
        #1;
        chk("cool_pos", 32'(b_pos), 3);
        tick();
        tick();

        // FIFO full on instance A: 6 requests, 4 queued, 2 dropped
        order_ready = 1'b0;
        do_reset();
        enable = 1'b1; stock_id = 2'd0; current_price = 14'd1000; buy_signal = 1'b1;
        tick();
        for (int k = 1; k < 6; k++) begin
            stock_id = 2'(k % 4);
            current_price = 14'(1000 + k);
            tick();
        end
        enable = 1'b0;
        tick();
        buy_signal = 1'b0;
        chk("full_valid", 32'(a_valid), 1);
        chk("full_drop", 32'(a_drop), 2);
        rd_pos_a("full_pos0", 2'd0, 4'd1);
        rd_pos_a("full_pos1", 2'd1, 4'd1);
        rd_pos_a("full_pos2", 2'd2, 4'd1);
        rd_pos_a("full_pos3", 2'd3, 4'd1);
        tick();
        chk("full_hold_id", 32'(a_id), 0);
        chk("full_hold_price", 32'(a_price), 1000);
        order_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("drain_side", 32'(a_side), 1);
            chk("drain_id", 32'(a_id), 32'(k));
            chk("drain_price", 32'(a_price), 32'(1000 + k));
            tick();
        end
        chk("drain_empty", 32'(a_valid), 0);

        // Illegal and idle inputs
        decide(2'd3, 14'd1500, 1'b0, 1'b1);
        chk("ill_setup_side", 32'(a_side), 0);
        tick();
        decide(2'd1, 14'd700, 1'b1, 1'b1);
        chk("ill_both", 32'(a_valid), 0);
        decide(2'd3, 14'd700, 1'b0, 1'b1);
        chk("ill_sell_empty", 32'(a_valid), 0);
        enable = 1'b0; stock_id = 2'd1; buy_signal = 1'b1;
        tick();
        tick();
        buy_signal = 1'b0;
        chk("ill_idle", 32'(a_valid), 0);
        rd_pos_a("ill_pos1", 2'd1, 4'd1);
        rd_pos_a("ill_pos3", 2'd3, 4'd0);
        chk("ill_drop", 32'(a_drop), 2);

        // Asynchronous reset with 3 orders queued
        order_ready = 1'b0;
        tick();
        enable = 1'b1; buy_signal = 1'b1;
        for (int k = 0; k < 3; k++) begin
            stock_id = 2'(k);
            current_price = 14'(3000 + k);
            tick();
        end
        enable = 1'b0;
        tick();
        buy_signal = 1'b0;
        chk("ar_pre_valid", 32'(a_valid), 1);
        chk("ar_pre_price", 32'(a_price), 3000);
        rd_pos_a("ar_pre_pos0", 2'd0, 4'd2);
        #1;
        rst = 1'b1;
        #1;
        chk("ar_valid", 32'(a_valid), 0);
        chk("ar_price", 32'(a_price), 0);
        chk("ar_drop", 32'(a_drop), 0);
        chk("ar_pos0", 32'(a_pos), 0);
        #1;
        rst = 1'b0;
        tick();
        chk("ar_after_valid", 32'(a_valid), 0);

        $display("%0d/%0d checks passed", pass_cnt, pass_cnt + fail_cnt);
        $finish;
    end

endmodule
